alu_arbiter: RTL

Round-robin arbiter and sequencer that shares a single ALU_TOP instance among NUM_REQ requesters. It accepts one operation at a time from a requester, drives the ALU operands, function code and Enable pulse, and waits for OUT_VALID. It then returns the captured result to the requester that owns the operation. It sits between the register-file/control clients and the ALU, and is the only agent that drives ALU inputs.

---
 rtl/alu_arbiter_if.sv | 22 ++
 rtl/alu_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side request/response bundle of alu_arbiter
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 16
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*4-1:0] req_fun;
  logic [WIDTH-1:0] rsp_data;
  logic rsp_err;
  modport master (
    output req_valid, req_a, req_b, req_fun,
    input req_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input req_valid, req_a, req_b, req_fun,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one ALU among NUM_REQ requesters.
// Defining ALU_ARB_TIMEOUT_EN adds a WAIT-state timeout that aborts with rsp_err.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 16,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic RST,
  alu_arbiter_if.slave bus,
  output logic busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0] alu_fun,
  output logic alu_enable,
  input logic [WIDTH-1:0] alu_out,
  input logic alu_out_valid
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IW-1:0] ptr, owner, gnt, idx;
  logic found;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [3:0] sel_fun;
  logic [NUM_REQ-1:0] own_oh;
  // first set request bit searching upward from ptr+1, wrapping
  always_comb begin
    gnt = ptr;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_fun = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (IW'(i) == gnt) begin
        sel_a = bus.req_a[i*WIDTH +: WIDTH];
        sel_b = bus.req_b[i*WIDTH +: WIDTH];
        sel_fun = bus.req_fun[i*4 +: 4];
      end
  end
  assign own_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign bus.req_ready = (state == IDLE && found && !RST) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt : '0;
  assign busy = state != IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic err, expired;
  assign expired = cnt == CW'(TIMEOUT - 1);
  assign bus.rsp_err = err;
`else
  assign bus.rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      owner <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_fun <= '0;
      alu_enable <= 1'b0;
      bus.rsp_valid <= '0;
      bus.rsp_data <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt <= '0;
      err <= 1'b0;
`endif
    end else begin
      alu_enable <= 1'b0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE:
          if (found) begin
            alu_a <= sel_a;
            alu_b <= sel_b;
            alu_fun <= sel_fun;
            owner <= gnt;
            alu_enable <= 1'b1;
            state <= ISSUE;
          end
        ISSUE: begin
          state <= WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        WAIT:
          if (alu_out_valid) begin
            bus.rsp_data <= alu_out;
            bus.rsp_valid <= own_oh;
            state <= RESP;
`ifdef ALU_ARB_TIMEOUT_EN
            err <= 1'b0;
          end else if (expired) begin
            bus.rsp_data <= '0;
            bus.rsp_valid <= own_oh;
            err <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        default: begin
          ptr <= owner;
          state <= IDLE;
        end
      endcase
    end
endmodule
